// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Brings the ECP5 PLL from power-up to a known-good running state and keeps
// the downstream logic in reset until the PLL clocks can be trusted. The
// sequence is:
//   1. Hold the PLL in reset for a fixed time.
//   2. Wait for a debounced lock, with a timeout that retries the PLL.
//   3. Release the system reset after a settling delay.
// If lock is lost while running, the system reset is re-asserted and the PLL
// is restarted.
//
// Optional feature: define PLL_SEQ_FAULT_EN to stop retrying after
// MAX_RETRIES consecutive lock timeouts. The block then parks in FAULT until
// rst is asserted. Without the macro, retries are unlimited and fault is 0.
//
// Ports:
//   clkin_25MHz      free-running 25 MHz oscillator; the only clock
//   rst              synchronous, active-high reset
//   locked           PLL LOCK, asynchronous to clkin_25MHz
//   pll_rst          PLL RST, active-high
//   sys_rst          reset for the downstream clock domains, active-high
//   ready            high only in RUN
//   state            current state encoding (debug)
//   lock_loss_count  saturating count of lock losses seen in RUN
//   fault            retry limit exhausted (0 when the feature is compiled out)
module pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 250000,
   parameter int unsigned LOCK_STABLE   = 1024,
   parameter int unsigned RELEASE_DELAY = 64,
   parameter int unsigned MAX_RETRIES   = 4,
   parameter int unsigned CNT_W         = 20
) (
   input  logic       clkin_25MHz,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [2:0] state,
   output logic [7:0] lock_loss_count,
   output logic       fault
);

   if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1 || RELEASE_DELAY < 1 ||
       MAX_RETRIES < 1 || $clog2(RST_CYCLES) > CNT_W || $clog2(LOCK_TIMEOUT) > CNT_W ||
       $clog2(LOCK_STABLE) > CNT_W || $clog2(RELEASE_DELAY) > CNT_W) begin : g_param_check
      $error("pll_reset_sequencer: invalid parameter set");
   end

   typedef enum logic [2:0] {
      StResetPll = 3'd0,
      StWaitLock = 3'd1,
      StHold     = 3'd2,
      StRun      = 3'd3,
      StFault    = 3'd4
   } state_e;

   // Counters compare against "last" values. They start at 0 on state entry, so
   // the state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(RELEASE_DELAY - 1);

   state_e           state_q, state_d;
   logic [1:0]       sync_q;
   logic             lk;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic [7:0]       llc_q, llc_d;

`ifdef PLL_SEQ_FAULT_EN
   localparam int unsigned   RetW      = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
   localparam logic [RetW-1:0] RetryLast = RetW'(MAX_RETRIES - 1);
   logic [RetW-1:0] retries_q, retries_d;
`endif

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge clkin_25MHz) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], locked};
      end
   end

   assign lk = sync_q[1];

   // State and counter registers.
   always_ff @(posedge clkin_25MHz) begin
      if (rst) begin
         state_q   <= StResetPll;
         tcnt_q    <= '0;
         scnt_q    <= '0;
         llc_q     <= '0;
`ifdef PLL_SEQ_FAULT_EN
         retries_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         scnt_q    <= scnt_d;
         llc_q     <= llc_d;
`ifdef PLL_SEQ_FAULT_EN
         retries_q <= retries_d;
`endif
      end
   end

   // Next-state logic. tcnt counts in RESET_PLL, WAIT_LOCK and HOLD. It is zero
   // by default, so every state change clears it.
   always_comb begin
      state_d   = state_q;
      tcnt_d    = '0;
      scnt_d    = '0;
      llc_d     = llc_q;
`ifdef PLL_SEQ_FAULT_EN
      retries_d = retries_q;
`endif
      case (state_q)
         StResetPll: begin
            if (tcnt_q == RstLast) begin
               state_d = StWaitLock;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         StWaitLock: begin
            tcnt_d = tcnt_q + 1'b1;
            scnt_d = lk ? scnt_q + 1'b1 : '0;
            // scnt reaching LOCK_STABLE this cycle takes priority over the timeout.
            if (lk && scnt_q == StableLast) begin
               state_d = StHold;
               tcnt_d  = '0;
               scnt_d  = '0;
            end else if (tcnt_q == TimeoutLast) begin
               tcnt_d = '0;
               scnt_d = '0;
`ifdef PLL_SEQ_FAULT_EN
               if (retries_q == RetryLast) begin
                  state_d = StFault;
               end else begin
                  state_d   = StResetPll;
                  retries_d = retries_q + 1'b1;
               end
`else
               state_d = StResetPll;
`endif
            end
         end
         StHold: begin
            if (!lk) begin
               state_d = StResetPll;
            end else if (tcnt_q == ReleaseLast) begin
               state_d = StRun;
`ifdef PLL_SEQ_FAULT_EN
               retries_d = '0;
`endif
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         StRun: begin
            if (!lk) begin
               state_d = StResetPll;
               if (llc_q != 8'hff) begin
                  llc_d = llc_q + 8'd1;
               end
            end
         end
`ifdef PLL_SEQ_FAULT_EN
         StFault: begin
            state_d = StFault;
         end
`endif
         default: begin
            state_d = StResetPll;
         end
      endcase
   end

   // Outputs decode from the registered state only.
   always_comb begin
      pll_rst = (state_q == StResetPll) || (state_q == StFault);
      sys_rst = (state_q != StRun);
      ready   = (state_q == StRun);
`ifdef PLL_SEQ_FAULT_EN
      fault   = (state_q == StFault);
`else
      fault   = 1'b0;
`endif
   end

   assign state           = state_q;
   assign lock_loss_count = llc_q;

endmodule
